// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Fetch-address sequencer and pipeline hazard controller for a 5-stage
//   in-order pipeline. Owns the program counter and decides, once per cycle,
//   whether the pipeline advances, stalls, flushes, redirects or halts.
//
//   Per-cycle event priority:
//     dmem_busy > branch_taken > halt_id > load_use > !imem_ready > advance
//
// Ports
//   clk              sole clock, rising edge
//   rst              asynchronous active-high reset
//   i_imem_ready     instruction word for the current pc is valid this cycle
//   i_load_use       load-use hazard detected in ID
//   i_halt_id        HLT opcode in ID
//   i_dmem_busy      data memory stall, freezes the whole pipeline
//   i_branch_taken   branch in MEM resolved taken (meaningful when not busy)
//   i_branch_target  redirect address from MEM (bit 0 is forced to 0)
//   o_pc             registered fetch address
//   o_freeze         hold every pipeline register
//   o_flush_if_id    bubble into IF/ID at the next edge
//   o_flush_id_ex    bubble into ID/EX at the next edge
//   o_flush_ex_mem   bubble into EX/MEM at the next edge
//   o_halted         registered, high while in HALTED
//   o_state          RUN=00, FROZEN=01, DRAIN=10, HALTED=11
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_imem_ready,
  input  logic        i_load_use,
  input  logic        i_halt_id,
  input  logic        i_dmem_busy,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_target,
  output logic [15:0] o_pc,
  output logic        o_freeze,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_flush_ex_mem,
  output logic        o_halted,
  output logic [1:0]  o_state
);

  localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FROZEN = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t        r_state;
  logic [15:0]   r_pc;
  logic [CW-1:0] r_cnt;
  logic          r_halted;

  state_t        w_state_next;
  logic [15:0]   w_pc_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_halted_next;

  // One-hot event decode shared by the next-state and output processes.
  // FROZEN without dmem_busy behaves exactly like RUN in the same cycle.
  logic w_live, w_stall, w_active, w_run_like, w_in_drain;
  logic w_redirect, w_halt, w_load_use, w_fetch_miss, w_advance, w_drain_step;

  assign w_live       = (r_state != ST_HALTED);
  assign w_stall      = w_live & i_dmem_busy;
  assign w_active     = w_live & ~i_dmem_busy;
  assign w_run_like   = w_active & ((r_state == ST_RUN) | (r_state == ST_FROZEN));
  assign w_in_drain   = w_active & (r_state == ST_DRAIN);
  // A taken branch is older than anything in ID, so it also aborts a drain.
  assign w_redirect   = w_active & i_branch_taken;
  assign w_halt       = w_run_like & ~i_branch_taken & i_halt_id;
  assign w_load_use   = w_run_like & ~i_branch_taken & ~i_halt_id & i_load_use;
  assign w_fetch_miss = w_run_like & ~i_branch_taken & ~i_halt_id & ~i_load_use
                        & ~i_imem_ready;
  assign w_advance    = w_run_like & ~i_branch_taken & ~i_halt_id & ~i_load_use
                        & i_imem_ready;
  assign w_drain_step = w_in_drain & ~i_branch_taken;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_cnt    <= w_cnt_next;
      r_halted <= w_halted_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_cnt_next    = r_cnt;
    w_halted_next = r_halted;

    // Busy in FROZEN or DRAIN keeps the current state; only RUN moves.
    if (w_stall && r_state == ST_RUN) begin
      w_state_next = ST_FROZEN;
    end

    if (w_run_like) begin
      w_state_next = ST_RUN;
    end

    if (w_redirect) begin
      w_pc_next    = {i_branch_target[15:1], 1'b0};
      w_state_next = ST_RUN;
      w_cnt_next   = '0;
    end

    if (w_halt) begin
      if (DRAIN_CYCLES == 0) begin
        w_state_next  = ST_HALTED;
        w_halted_next = 1'b1;
        w_cnt_next    = '0;
      end else begin
        w_state_next = ST_DRAIN;
        w_cnt_next   = DRAIN_LOAD;
      end
    end

    if (w_advance) begin
      w_pc_next = r_pc + 16'd2;
    end

    if (w_drain_step) begin
      if (r_cnt <= CW'(1)) begin
        w_cnt_next    = '0;
        w_state_next  = ST_HALTED;
        w_halted_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt - CW'(1);
      end
    end
  end

  // Output logic: all control strobes are forced low while reset is held.
  always_comb begin
    o_freeze       = 1'b0;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    o_flush_ex_mem = 1'b0;
    if (!rst) begin
      o_freeze       = (r_state == ST_HALTED) | w_stall;
      o_flush_if_id  = w_redirect | w_halt | w_fetch_miss | w_drain_step;
      o_flush_id_ex  = w_redirect | w_load_use;
      o_flush_ex_mem = w_redirect;
    end
  end

  assign o_pc     = r_pc;
  assign o_halted = r_halted;
  assign o_state  = r_state;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, meaning the number of non-frozen cycles from HLT decode to the HALTED state.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 imem_ready  in  1  instruction memory returns a valid word for the current pc this cycle.
REQ-006 load_use  in  1  ID-stage load-use hazard detected.
REQ-007 halt_id  in  1  HLT opcode present in ID.
REQ-008 dmem_busy  in  1  data memory stall; freezes the entire pipeline.
REQ-009 branch_taken  in  1  branch resolved taken in MEM; valid only when dmem_busy=0.
REQ-010 branch_target  in  16  redirect address from MEM.
REQ-011 pc  out  16  current fetch address, registered.
REQ-012 freeze  out  1  hold all pipeline registers.
REQ-013 flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  insert a bubble into that pipeline register at the next edge.
REQ-014 halted  out  1  registered; high while in HALTED.
REQ-015 state  out  2  RUN=00, FROZEN=01, DRAIN=10, HALTED=11.

Function
REQ-016 SHALL implement an FSM with states RUN, FROZEN, DRAIN and HALTED.
REQ-017 Event priority per cycle SHALL be: dmem_busy > branch_taken > halt_id > load_use > !imem_ready > normal advance.
REQ-018 In any state except HALTED, dmem_busy=1: freeze=1, all flushes=0, pc holds.
REQ-018a Entering on dmem_busy=1: from RUN -> FROZEN; from DRAIN the state remains DRAIN.
REQ-019 FROZEN with dmem_busy=0 SHALL return to RUN in the same cycle it evaluates; events that cycle are processed as in RUN.
REQ-020 RUN, branch_taken=1: pc <= {branch_target[15:1],1'b0}; flush_if_id, flush_id_ex and flush_ex_mem all high that cycle; stay RUN.
REQ-021 RUN, halt_id=1, no branch: pc holds; flush_if_id=1; counter <= DRAIN_CYCLES; state -> DRAIN.
REQ-022 RUN, load_use=1: pc holds; flush_id_ex=1; IF/ID holds via freeze=0 plus internal pc hold (flush_if_id=0).
REQ-023 RUN, imem_ready=0: pc holds; flush_if_id=1.
REQ-024 RUN, normal advance: pc <= pc + 2, modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-025 DRAIN: pc holds; flush_if_id=1 every cycle; counter decrements only when dmem_busy=0.
REQ-025a DRAIN, counter reaching 0: state -> HALTED.
REQ-026 DRAIN with branch_taken=1 (an older branch in MEM) SHALL abort the drain: redirect as in REQ-020 and state -> RUN.
REQ-027 HALTED: pc holds, freeze=1, halted=1, all flushes=0; all inputs are ignored until rst.
REQ-028 All flush and freeze outputs SHALL be combinational from state and inputs; pc, state, counter and halted SHALL be registered.
REQ-029 branch_target bit 0 SHALL be forced to 0 on every load.

Reset
REQ-030 rst=1 SHALL immediately force: pc=RESET_PC, state=RUN, counter=0, halted=0.
REQ-030a While rst=1, freeze and all flushes SHALL be 0.
REQ-031 rst asserted mid-DRAIN or while in HALTED SHALL abandon the operation; fetch resumes at RESET_PC on the first edge after rst deasserts.

Verification
REQ-032 Reset, imem_ready=1, no events for 4 cycles -> pc sequence 0000, 0002, 0004, 0006, 0008; state=00.
REQ-033 pc=16'hFFFE with normal advance -> pc=16'h0000 on the next edge.
REQ-034 pc=0010, branch_taken=1, branch_target=16'h0041 -> three flushes high that cycle; pc=16'h0040 at the next edge.
REQ-035 halt_id=1 at pc=0020, dmem_busy=1 for 2 of the following cycles -> state 10 for 5 cycles, then 11; halted=1; pc stays 0020.
REQ-036 DRAIN entered, then branch_taken=1 with target 0x0100 on the second drain cycle -> state=00; pc=0100; halted stays 0.
REQ-037 dmem_busy=1 and branch_taken=1 together -> freeze=1, no flush, pc holds; on release with branch_taken=1 -> redirect taken.
